// File: rtl/clock_monitor_pkg.sv
// clock_monitor_pkg
//   Shared types and parameter defaults for the clock monitor.
//   - state_e   : measurement FSM states
//   - DEF_*     : default values for the clock_monitor parameters
//   - abs_diff  : unsigned absolute difference used by the lock comparator
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STALL = 2'd3
    } state_e;

    localparam int DEF_COUNTER_WIDTH  = 16;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_LOCK_COUNT     = 4;
    localparam int DEF_LOCK_TOLERANCE = 1;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clock_monitor_sync_edge_detect.sv
// sync_edge_detect
//   Brings an asynchronous single-bit input into the iClk domain through a
//   flop chain and derives one-cycle rise/fall strobes from the settled bit.
//   Ports:
//     iClk   : sampling clock
//     nRst   : asynchronous active-low reset
//     iD     : asynchronous input
//     oRise  : one-cycle strobe, synchronized level went 0 -> 1
//     oFall  : one-cycle strobe, synchronized level went 1 -> 0
//     oLevel : synchronized level (last flop of the chain)
module sync_edge_detect #(
    parameter int SyncStages = 2
) (
    input  logic iClk,
    input  logic nRst,
    input  logic iD,
    output logic oRise,
    output logic oFall,
    output logic oLevel
);

    logic [SyncStages-1:0] sync_q;
    logic [SyncStages-1:0] sync_d;
    logic                  prev_q;
    logic                  prev_d;

    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], iD};
        prev_d = sync_q[SyncStages-1];
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign oLevel = sync_q[SyncStages-1];
    assign oRise  = oLevel & ~prev_q;
    assign oFall  = ~oLevel & prev_q;

endmodule

// File: rtl/clock_monitor.sv
// clock_monitor
//   Measures an asynchronous monitored clock in iClk cycles: period and high
//   time of each completed cycle, lock once the period is stable, and a stall
//   flag when edges stop arriving.
//   Ports:
//     iClk      : system clock
//     nRst      : asynchronous active-low reset
//     iMonClk   : monitored clock, asynchronous to iClk
//     iClear    : synchronous clear of all measurement state
//     oPeriod   : last completed period (iClk cycles)
//     oHighTime : high time of that period (iClk cycles)
//     oValid    : one-cycle pulse when oPeriod/oHighTime update
//     oLocked   : period stable for LockCount consecutive comparisons
//     oStall    : no edge within TimeoutCycles
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | after reset/clear, waiting for the first rise (no report)
//   ST_HIGH  | monitored clock high, waiting for fall
//   ST_LOW   | monitored clock low, next rise completes a period
//   ST_STALL | timeout expired; next rise restarts without a report
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int CounterWidth  = DEF_COUNTER_WIDTH,
    parameter int SyncStages    = DEF_SYNC_STAGES,
    parameter int TimeoutCycles = DEF_TIMEOUT_CYCLES,
    parameter int LockCount     = DEF_LOCK_COUNT,
    parameter int LockTolerance = DEF_LOCK_TOLERANCE
) (
    input  logic                    iClk,
    input  logic                    nRst,
    input  logic                    iMonClk,
    input  logic                    iClear,
    output logic [CounterWidth-1:0] oPeriod,
    output logic [CounterWidth-1:0] oHighTime,
    output logic                    oValid,
    output logic                    oLocked,
    output logic                    oStall
);

    localparam logic [CounterWidth-1:0] TIMEOUT = CounterWidth'(TimeoutCycles);
    localparam logic [CounterWidth-1:0] CNT_ONE = CounterWidth'(1);
    localparam int                      LockW   = $clog2(LockCount + 1);
    localparam logic [LockW-1:0]        LOCK_FULL = LockW'(LockCount);
    localparam logic [LockW-1:0]        LOCK_ONE  = LockW'(1);

    logic mon_rise;
    logic mon_fall;
    logic mon_level;

    sync_edge_detect #(
        .SyncStages (SyncStages)
    ) u_sync (
        .iClk   (iClk),
        .nRst   (nRst),
        .iD     (iMonClk),
        .oRise  (mon_rise),
        .oFall  (mon_fall),
        .oLevel (mon_level)
    );

    state_e                  state_q, state_d;
    logic [CounterWidth-1:0] cnt_q, cnt_d;
    logic [CounterWidth-1:0] hcnt_q, hcnt_d;
    logic [CounterWidth-1:0] period_q, period_d;
    logic [CounterWidth-1:0] high_q, high_d;
    logic                    valid_q, valid_d;
    logic                    locked_q, locked_d;
    logic                    stall_q, stall_d;
    logic [LockW-1:0]        lock_cnt_q, lock_cnt_d;
    logic                    have_prev_q, have_prev_d;

    logic timeout;
    logic complete;
    logic in_tol;

    // >= rather than ==: a fall taken on the exact timeout cycle moves to
    // ST_LOW with cnt already past the limit, and that must still time out.
    assign timeout  = (cnt_q >= TIMEOUT);
    assign complete = (state_q == ST_LOW) && mon_rise;
    assign in_tol   = abs_diff(32'(cnt_q), 32'(period_q)) <= 32'(LockTolerance);

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            stall_q     <= 1'b0;
            lock_cnt_q  <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            stall_q     <= stall_d;
            lock_cnt_q  <= lock_cnt_d;
            have_prev_q <= have_prev_d;
        end
    end

    // Edge strobes win over the timeout: a period of exactly TimeoutCycles
    // is still reported rather than declared a stall.
    always_comb begin
        state_d = state_q;
        if (iClear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mon_rise) state_d = ST_HIGH;
                end
                ST_HIGH: begin
                    if (mon_fall)      state_d = ST_LOW;
                    else if (mon_rise) state_d = ST_HIGH;
                    else if (timeout)  state_d = ST_STALL;
                end
                ST_LOW: begin
                    if (mon_rise)     state_d = ST_HIGH;
                    else if (timeout) state_d = ST_STALL;
                end
                ST_STALL: begin
                    if (mon_rise) state_d = ST_HIGH;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        stall_d     = (state_d == ST_STALL);
        lock_cnt_d  = lock_cnt_q;
        have_prev_d = have_prev_q;

        if (iClear) begin
            cnt_d       = '0;
            hcnt_d      = '0;
            period_d    = '0;
            high_d      = '0;
            locked_d    = 1'b0;
            stall_d     = 1'b0;
            lock_cnt_d  = '0;
            have_prev_d = 1'b0;
        end else begin
            // cnt stays at 0 in ST_IDLE and saturates instead of wrapping.
            if (mon_rise) begin
                cnt_d = CNT_ONE;
            end else if ((state_q != ST_IDLE) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_ONE;
            end

            if ((state_q == ST_HIGH) && mon_fall) begin
                hcnt_d = cnt_q;
            end

            if (complete) begin
                period_d    = cnt_q;
                high_d      = hcnt_q;
                valid_d     = 1'b1;
                have_prev_d = 1'b1;
                // The first period after IDLE/STALL has nothing to compare with.
                if (have_prev_q) begin
                    if (in_tol) begin
                        if (lock_cnt_q != LOCK_FULL) lock_cnt_d = lock_cnt_q + LOCK_ONE;
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
                locked_d = (lock_cnt_d == LOCK_FULL);
            end

            if (state_d == ST_STALL) begin
                locked_d    = 1'b0;
                lock_cnt_d  = '0;
                have_prev_d = 1'b0;
            end
        end
    end

    assign oPeriod   = period_q;
    assign oHighTime = high_q;
    assign oValid    = valid_q;
    assign oLocked   = locked_q;
    assign oStall    = stall_q;

    // The phase states must agree with the synchronized level: leaving HIGH
    // requires a fall, leaving LOW requires a rise, so the level can only
    // disagree in the cycle that carries the corresponding strobe.
    high_phase_level: assert property (@(posedge iClk) disable iff (!nRst)
        (state_q == ST_HIGH) |-> (mon_level || mon_fall));
    low_phase_level: assert property (@(posedge iClk) disable iff (!nRst)
        (state_q == ST_LOW) |-> (!mon_level || mon_rise));

endmodule

// File: tb/tb_clock_monitor.sv
module tb_clock_monitor;

    localparam int T_A = 1000;
    localparam int NV  = 18;

    logic        clk = 1'b0;
    logic        nRst;
    logic        mon_a, mon_b;
    logic        clr_a, clr_b;
    logic [15:0] period_a, high_a;
    logic        valid_a, locked_a, stall_a;
    logic [3:0]  period_b, high_b;
    logic        valid_b, locked_b, stall_b;

    always #5 clk = ~clk;

    clock_monitor #(
        .CounterWidth  (16),
        .SyncStages    (2),
        .TimeoutCycles (T_A),
        .LockCount     (4),
        .LockTolerance (1)
    ) dut_a (
        .iClk      (clk),
        .nRst      (nRst),
        .iMonClk   (mon_a),
        .iClear    (clr_a),
        .oPeriod   (period_a),
        .oHighTime (high_a),
        .oValid    (valid_a),
        .oLocked   (locked_a),
        .oStall    (stall_a)
    );

    clock_monitor #(
        .CounterWidth  (4),
        .SyncStages    (2),
        .TimeoutCycles (15),
        .LockCount     (4),
        .LockTolerance (1)
    ) dut_b (
        .iClk      (clk),
        .nRst      (nRst),
        .iMonClk   (mon_b),
        .iClear    (clr_b),
        .oPeriod   (period_b),
        .oHighTime (high_b),
        .oValid    (valid_b),
        .oLocked   (locked_b),
        .oStall    (stall_b)
    );

    typedef struct {
        int hi;
        int lo;
        int period;
        int high;
        int locked;
    } vec_t;

    typedef struct {
        int period;
        int high;
        int locked;
    } obs_t;

    vec_t vecs [NV];
    obs_t q_a[$];
    obs_t q_b[$];
    bit   stall_seen_b = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always @(negedge clk) begin
        if (valid_a === 1'b1) q_a.push_back('{int'(period_a), int'(high_a), int'(locked_a)});
        if (valid_b === 1'b1) q_b.push_back('{int'(period_b), int'(high_b), int'(locked_b)});
        if (stall_b === 1'b1) stall_seen_b = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_obs_a(input string tag, input int idx, input int p, input int h, input int l);
        if (q_a.size() > idx) begin
            check($sformatf("%s_period", tag), q_a[idx].period, p);
            check($sformatf("%s_high", tag), q_a[idx].high, h);
            check($sformatf("%s_locked", tag), q_a[idx].locked, l);
        end else begin
            check($sformatf("%s_present", tag), q_a.size(), idx + 1);
        end
    endtask

    task automatic check_obs_b(input string tag, input int idx, input int p, input int h);
        if (q_b.size() > idx) begin
            check($sformatf("%s_period", tag), q_b[idx].period, p);
            check($sformatf("%s_high", tag), q_b[idx].high, h);
        end else begin
            check($sformatf("%s_present", tag), q_b.size(), idx + 1);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mon_set(input int which, input logic v);
        if (which == 0) mon_a = v;
        else mon_b = v;
    endtask

    // One full monitored-clock cycle starting with a rise, driven on negedges.
    task automatic mon_period(input int which, input int hi, input int lo);
        mon_set(which, 1'b1);
        wait_neg(hi);
        mon_set(which, 1'b0);
        wait_neg(lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stall_at;

        vecs[0]  = '{5, 5, 10, 5, 0};
        vecs[1]  = '{5, 5, 10, 5, 0};
        vecs[2]  = '{5, 5, 10, 5, 0};
        vecs[3]  = '{5, 5, 10, 5, 0};
        vecs[4]  = '{5, 5, 10, 5, 1};
        vecs[5]  = '{5, 5, 10, 5, 1};
        vecs[6]  = '{6, 7, 13, 6, 0};
        vecs[7]  = '{5, 5, 10, 5, 0};
        vecs[8]  = '{5, 5, 10, 5, 0};
        vecs[9]  = '{5, 5, 10, 5, 0};
        vecs[10] = '{5, 5, 10, 5, 0};
        vecs[11] = '{5, 5, 10, 5, 1};
        vecs[12] = '{3, 8, 11, 3, 1};
        vecs[13] = '{7, 2,  9, 7, 0};
        vecs[14] = '{2, 7,  9, 2, 0};
        vecs[15] = '{5, 4,  9, 5, 0};
        vecs[16] = '{4, 5,  9, 4, 0};
        vecs[17] = '{5, 4,  9, 5, 1};

        nRst  = 1'b0;
        mon_a = 1'b0;
        mon_b = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;

        #3;
        check("rst_period", int'(period_a), 0);
        check("rst_high", int'(high_a), 0);
        check("rst_valid", int'(valid_a), 0);
        check("rst_locked", int'(locked_a), 0);
        check("rst_stall", int'(stall_a), 0);
        check("rst_period_b", int'(period_b), 0);

        wait_neg(2);
        nRst = 1'b1;
        wait_neg(3);

        // Table-driven periods; each report appears at the next rise.
        for (int i = 0; i < NV; i++) mon_period(0, vecs[i].hi, vecs[i].lo);
        mon_a = 1'b1;

        // Clock stuck high: stall must appear exactly at the expected cycle.
        stall_at = -1;
        for (int i = 1; i <= T_A + 50; i++) begin
            @(negedge clk);
            if (stall_a === 1'b1) begin
                stall_at = i;
                break;
            end
        end
        check("stall_latency", stall_at, T_A + 3);
        check("stall_unlocked", int'(locked_a), 0);
        check("vec_count", q_a.size(), NV);
        for (int i = 0; i < NV; i++)
            check_obs_a($sformatf("vec%0d", i), i, vecs[i].period, vecs[i].high, vecs[i].locked);

        // Restart: stall clears after the rise strobe, partial period dropped.
        mon_a = 1'b0;
        wait_neg(5);
        mon_a = 1'b1;
        wait_neg(2);
        check("stall_hold", int'(stall_a), 1);
        wait_neg(1);
        check("stall_clear", int'(stall_a), 0);
        wait_neg(2);
        mon_a = 1'b0;
        wait_neg(5);
        mon_period(0, 5, 5);
        mon_a = 1'b1;
        wait_neg(6);
        check("restart_count", q_a.size(), NV + 2);
        check_obs_a("restart0", NV, 10, 5, 0);
        check_obs_a("restart1", NV + 1, 10, 5, 0);

        // Async reset in the middle of a high phase.
        #2;
        nRst = 1'b0;
        #1;
        check("arst_period", int'(period_a), 0);
        check("arst_high", int'(high_a), 0);
        check("arst_valid", int'(valid_a), 0);
        check("arst_locked", int'(locked_a), 0);
        check("arst_stall", int'(stall_a), 0);
        mon_a = 1'b0;
        wait_neg(2);
        nRst = 1'b1;
        wait_neg(3);
        mon_period(0, 5, 5);
        mon_a = 1'b1;
        wait_neg(6);
        check("arst_count", q_a.size(), NV + 3);
        check_obs_a("arst0", NV + 2, 10, 5, 0);

        // Clear asserted on the cycle the rise strobe is sampled.
        mon_a = 1'b0;
        wait_neg(5);
        mon_a = 1'b1;
        wait_neg(2);
        clr_a = 1'b1;
        wait_neg(1);
        clr_a = 1'b0;
        check("clr_valid", int'(valid_a), 0);
        check("clr_period", int'(period_a), 0);
        check("clr_high", int'(high_a), 0);
        check("clr_locked", int'(locked_a), 0);
        check("clr_stall", int'(stall_a), 0);
        check("clr_no_report", q_a.size(), NV + 3);
        wait_neg(2);
        mon_a = 1'b0;
        wait_neg(5);
        mon_period(0, 5, 5);
        mon_period(0, 5, 5);
        mon_a = 1'b1;
        wait_neg(6);
        check("clr_count", q_a.size(), NV + 5);
        check_obs_a("clr0", NV + 3, 10, 5, 0);
        check_obs_a("clr1", NV + 4, 10, 5, 0);

        // Narrow counter: period 14 fits, period 20 must stall without a report.
        mon_period(1, 7, 7);
        mon_period(1, 7, 7);
        mon_b = 1'b1;
        wait_neg(4);
        check("b_count14", q_b.size(), 2);
        check("b_no_stall14", int'(stall_seen_b), 0);
        check_obs_b("b0", 0, 14, 7);
        check_obs_b("b1", 1, 14, 7);
        wait_neg(6);
        mon_b = 1'b0;
        wait_neg(10);
        mon_b = 1'b1;
        wait_neg(6);
        check("b_stall20", int'(stall_seen_b), 1);
        check("b_count20", q_b.size(), 2);
        check("b_period_hold", int'(period_b), 14);
        check("b_high_hold", int'(high_b), 7);
        check("b_stall_clear", int'(stall_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_monitor.md
# clock_monitor

Synthesizable clock-consumer block: samples an asynchronous monitored clock (e.g. `testClock` output or a divided PLL tap) in the `iClk` domain. Reports period and high time in `iClk` cycles, declares lock once the period is stable, and flags a stall when edges stop. Used in processor bring-up and in benches as the checking end of generated clocks.

## Interface
- `CounterWidth`, 16: width of period/high-time counters and outputs.
- `SyncStages`, 2: synchronizer flops on `iMonClk` (≥2).
- `TimeoutCycles`, 1000: `iClk` cycles without a detected edge before stall; must be < 2^CounterWidth.
- `LockCount`, 4: consecutive in-tolerance periods required for lock.
- `LockTolerance`, 1: max absolute period difference (cycles) still counted as stable.

Ports:
- `iClk` in 1: system clock.
- `nRst` in 1: reset; asynchronous, active-low.
- `iMonClk` in 1: monitored clock; asynchronous to `iClk`.
- `iClear` in 1: synchronous clear of measurement state.
- `oPeriod` out CounterWidth: last completed period, `iClk` cycles.
- `oHighTime` out CounterWidth: high time of that period.
- `oValid` out 1: one-cycle pulse when `oPeriod`/`oHighTime` update.
- `oLocked` out 1: period stable.
- `oStall` out 1: no edge within `TimeoutCycles`.

## Operation
- Reset (`nRst`=0, async): state IDLE; all outputs 0; sync chain, counters, and lock counter 0.
- `iMonClk` passes through `SyncStages` flops. Rise/fall strobes derive from last synced bit vs previous.
- `cnt` counts `iClk` cycles since last rise strobe. It is set to 1 in the cycle after a rise strobe and increments each cycle. It saturates at all-ones and never wraps.
- `hcnt` latches `cnt` at the fall strobe.
- States:
  - IDLE: wait for rise strobe → HIGH; `cnt`=1. No `oValid` for the first edge.
  - HIGH: fall strobe → LOW, `hcnt` latched. `cnt` reaching `TimeoutCycles` → STALL.
  - LOW: rise strobe → HIGH, `oPeriod`←`cnt`, `oHighTime`←`hcnt`, `oValid`=1 next cycle, `cnt` restarts. `cnt` reaching `TimeoutCycles` → STALL.
  - STALL: `oStall`=1, `oLocked`=0, lock counter 0. Rise strobe → HIGH, `oStall`=0, no `oValid` (partial period discarded).
- Lock:
  - On each `oValid`, compare new period against previous `oPeriod`.
  - If |diff| ≤ `LockTolerance`, increment the lock counter (saturating at `LockCount`). Otherwise clear it to 0 and deassert `oLocked`.
  - `oLocked`=1 when the counter reaches `LockCount`. The first period after IDLE/STALL has no predecessor and does not count.
- `iClear`=1: next state IDLE; outputs, counters, and lock cleared as in reset. Has priority over any simultaneous strobe or timeout.
- Rise and fall strobes are never both valid in one cycle. A monitored clock with a high or low phase shorter than 1 `iClk` cycle is out of contract.
- Saturation: `cnt` at all-ones holds. Timeout normally fires first, since `TimeoutCycles` < 2^CounterWidth.

## Timing
- Edge on `iMonClk` to strobe: `SyncStages`+1 `iClk` edges (±1 for metastability).
- Strobe to `oValid`/`oPeriod` update: 1 cycle, registered. `oPeriod` and `oHighTime` hold between pulses.
- `oLocked` updates in the same cycle as the `oValid` that completes the count. It drops in the same cycle as an out-of-tolerance `oValid`, or on STALL entry.
- `oStall` asserts the cycle after `cnt`==`TimeoutCycles`. It clears the cycle after the next rise strobe.
- Async reset mid-measurement clears everything immediately. After release, the first edge is treated as in IDLE.

## Structure
- `clock_monitor_pkg`: state enum (IDLE, HIGH, LOW, STALL) and shared parameter defaults.
- Sub-module `sync_edge_detect` (parameter `SyncStages`; ports `iClk`, `nRst`, `iD`, `oRise`, `oFall`, `oLevel`). Reusable for other async inputs.
- Top holds the FSM, counters, and lock logic.

## Test plan
- `testClock`-style stimulus, period 10 `iClk`, 50% duty → after the second rise, `oValid` pulses with `oPeriod`=10, `oHighTime`=5, then every 10 cycles.
- Steady 10-cycle clock → `oLocked`=1 at the 5th `oValid` (4 stable comparisons), held thereafter.
- Period 10 then one period of 13 (tolerance 1) → `oLocked` drops at that `oValid`. Relock after 4 more stable periods.
- Stop `iMonClk` high → `oStall`=1 exactly `TimeoutCycles`+1 cycles after the last rise strobe, `oLocked`=0. Restart → `oStall` clears, first `oValid` only after a full period.
- `nRst` pulsed low mid-HIGH, and `iClear` asserted on a rise-strobe cycle → all outputs 0, state IDLE, no `oValid` on that edge.
- `CounterWidth`=4, `TimeoutCycles`=15, period 14 → `oPeriod`=14, no stall. Period 20 → stall, no wrap-around value reported.
